lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
Load/store requester that drives the word-wide data memory port (clk, w_en, addr[7:0], data_in, data_out) from the core side. It accepts one byte, half or word load/store at a time, issues the memory accesses, and returns a single-cycle response. Sub-word stores use read-modify-write, because the memory has only a whole-word write enable. It sits between the execute stage and the data Mem instance.

Parameters:
ADDR_W, 8, byte-address width, matching the Mem addr port.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal size; no memory access performed
mem_w_en  out  1  to Mem w_en
mem_addr  out  ADDR_W  to Mem addr; always word-aligned ({req_addr[ADDR_W-1:2],2'b00})
mem_data_in  out  32  to Mem data_in
mem_data_out  in  32  from Mem data_out

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low (rst_n). State, response and memory-output registers change only on the rising edge of clk.
- Mem contract: synchronous read; mem_data_out is valid the cycle after mem_addr is presented. A write happens at the rising edge where mem_w_en=1.
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_w_en=0, mem_addr=0, mem_data_in=0; req_ready=1 once rst_n is high.
- Gating: mem_w_en is forced to 0 in any cycle where rst_n=0. Reset mid-operation abandons the request, issues no write and produces no response.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted at the edge where req_valid and req_ready are both 1; all req_* fields are latched there.
  - Only one request is outstanding. resp_valid is a pulse with no backpressure.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always an error.
- Lanes (little-endian):
  - byte k = data[8k+7:8k], where k = addr[1:0]
  - half h = data[16h+15:16h], where h = addr[1]
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RESP. T = acceptance cycle.
  - Misaligned/illegal: IDLE -> RESP. resp_valid=1, resp_err=1 in T+1. No memory access.
  - Load: IDLE -> RD_ADDR (T+1, mem_addr driven, w_en=0) -> RD_DATA (T+2, extract the lane from mem_data_out and extend into the rdata register) -> RESP (T+3, resp_valid=1).
  - Word store: IDLE -> WR (T+1, mem_w_en=1, mem_data_in=req_wdata) -> RESP (T+2).
  - Sub-word store: IDLE -> RD_ADDR (T+1) -> RD_DATA (T+2, merge the new lane into mem_data_out, other lanes unchanged) -> WR (T+3, mem_w_en=1, merged word) -> RESP (T+4).
  - RESP -> IDLE unconditionally. The next request can be accepted in the cycle after RESP.
- Response outputs: resp_rdata and resp_err are valid only while resp_valid=1 and are held at 0 otherwise.
- Write enable: mem_w_en is high for exactly one cycle per store and never high for loads or errors.
- mem_addr holds the last driven value outside active states. mem_data_in holds the last written value.
- Address wrap: the address is used modulo 2^ADDR_W; no carry out, no error.

Test Plan:
1. Preload Mem[0x04]=0x87654321; load word addr 0x04 -> resp_valid at T+3, resp_rdata=0x87654321, resp_err=0, mem_w_en never 1.
2. Same word:
   - signed byte 0x07 -> 0xFFFFFF87
   - unsigned byte 0x07 -> 0x00000087
   - signed half 0x06 -> 0xFFFF8765
   - signed half 0x04 -> 0x00004321
3. Store byte, wdata=0x123456AB, addr 0x05 -> mem_w_en high only in T+3 with mem_addr=0x04, mem_data_in=0x8765AB21; resp at T+4. A following word load from 0x04 returns 0x8765AB21.
4. Store word 0xFFFFFFFF to 0x08 -> mem_w_en at T+1 with mem_addr=0x08, resp_valid at T+2, resp_rdata=0. Back-to-back requests with req_valid held high are accepted only while in IDLE.
5. Misaligned cases -> resp_valid=1 and resp_err=1 at T+1, no mem_w_en, memory contents unchanged:
   - load half 0x05
   - store word 0x0A
   - size 11
6. Sub-word store to 0x05 with rst_n driven low during RD_DATA -> no mem_w_en pulse, no resp_valid; after rst_n returns high, state is IDLE, req_ready=1 and Mem[0x04] is unchanged.

Source files
------------

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//
// Purpose:
//   Load/store requester between the execute stage and a word-wide data
//   memory with a synchronous read and a whole-word write enable. It takes
//   one byte, half or word access at a time and returns a single-cycle
//   response pulse. Loads are lane-extracted and sign/zero-extended.
//   Sub-word stores are done as read-modify-write because the memory cannot
//   write individual bytes.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   req_valid     request present
//   req_ready     high while idle; a request is taken when valid & ready
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address (wraps modulo 2^ADDR_W)
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle response pulse
//   resp_rdata    extended load data, 0 for stores and errors
//   resp_err      misaligned access or illegal size, no memory access made
//   mem_w_en      memory write enable (forced low while rst_n is low)
//   mem_addr      word-aligned memory address
//   mem_data_in   memory write data
//   mem_data_out  memory read data, valid the cycle after mem_addr
// ---------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  logic [2:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_in_q, mem_data_in_d;

  logic              misaligned;
  logic [ADDR_W-1:0] alignedAddr;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [31:0]       loadData;
  logic [31:0]       laneMask;
  logic [31:0]       laneData;
  logic [31:0]       mergedWord;

  // Alignment check on the incoming request; size 11 is never legal.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = req_addr[0];
      SIZE_W:  misaligned = req_addr[1] | req_addr[0];
      default: misaligned = 1'b1;
    endcase
  end

  // Memory only ever sees word addresses; the low two bits select a lane.
  assign alignedAddr = {req_addr[ADDR_W-1:2], 2'b00};

  // Lane extraction for loads: little-endian, byte k at bits 8k+7:8k and
  // half h at bits 16h+15:16h.
  assign loadByte = mem_data_out[{lane_q, 3'b000} +: 8];
  assign loadHalf = mem_data_out[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    loadData = mem_data_out;
    case (size_q)
      SIZE_B:  loadData = uns_q ? {24'h000000, loadByte}
                                : {{24{loadByte[7]}}, loadByte};
      SIZE_H:  loadData = uns_q ? {16'h0000, loadHalf}
                                : {{16{loadHalf[15]}}, loadHalf};
      default: loadData = mem_data_out;
    endcase
  end

  // Read-modify-write merge: clear the target lane in the word just read
  // and drop the new data into it; every other lane is left untouched.
  always_comb begin
    laneMask = 32'h0000_0000;
    laneData = 32'h0000_0000;
    if (size_q == SIZE_B) begin
      laneMask = 32'h0000_00FF << {lane_q, 3'b000};
      laneData = {24'h000000, wdata_q[7:0]} << {lane_q, 3'b000};
    end else begin
      laneMask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      laneData = {16'h0000, wdata_q} << {lane_q[1], 4'b0000};
    end
    mergedWord = (mem_data_out & ~laneMask) | (laneData & laneMask);
  end

  // Next-state logic. Response and write-enable registers default to 0 so
  // they can only pulse for one cycle; mem_addr and mem_data_in hold their
  // last driven values unless a state explicitly updates them.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = 32'h0000_0000;
    resp_err_d    = 1'b0;
    mem_w_en_d    = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (misaligned) begin
            // Rejected without touching memory; answer next cycle.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_size == SIZE_W)) begin
            // Whole-word store needs no read, so write immediately.
            state_d       = WR;
            mem_addr_d    = alignedAddr;
            mem_w_en_d    = 1'b1;
            mem_data_in_d = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_d    = RD_ADDR;
            mem_addr_d = alignedAddr;
          end
        end
      end

      RD_ADDR: begin
        state_d = RD_DATA;
      end

      RD_DATA: begin
        if (we_q) begin
          state_d       = WR;
          mem_w_en_d    = 1'b1;
          mem_data_in_d = mergedWord;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = loadData;
        end
      end

      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset abandons any in-flight request outright, which
  // also cancels a pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
      resp_err_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_w_en_q    <= mem_w_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  // The enable is gated directly by rst_n so a write can never reach the
  // memory during a reset cycle, even before the register clears.
  assign mem_w_en    = mem_w_en_q & rst_n;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule
